mul_div_unit: RTL

- Iterative multiply/divide engine executing MUL AB and DIV AB.
- Consumes the current accumulator and B register values and produces new ACC, B, OV and CY values.
- Its result bus, together with a one-cycle write strobe, feeds the accumulator SFR and the B SFR write ports. Its flag outputs feed the PSW write-back.
- Sits between the core decode/execute stage and the SFR bank.

---
 rtl/mul_div_unit_if.sv | 26 ++
 rtl/mul_div_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between the execute stage and the MUL/DIV engine

interface mul_div_unit_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic              op_div;
    logic [DATA_W-1:0] acc_in;
    logic [DATA_W-1:0] b_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] acc_out;
    logic [DATA_W-1:0] b_out;
    logic              ov_out;
    logic              cy_out;

    modport master (
        output start, op_div, acc_in, b_in,
        input  busy, done, acc_out, b_out, ov_out, cy_out
    );

    modport slave (
        input  start, op_div, acc_in, b_in,
        output busy, done, acc_out, b_out, ov_out, cy_out
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MUL AB / DIV AB engine producing new ACC, B, OV and CY

module mul_div_unit #(
    parameter int DATA_W = 8
) (
    input  logic           clock,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              is_div;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] part_hi;
    logic [DATA_W-1:0] part_lo;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] b_q;
    logic              ov_q;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.op_div && bus.b_in == '0) ? DONE : CALC;
                end
            end
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // {part_hi, part_lo} is the product for MUL and {remainder, quotient} for DIV,
    // so both operations drain into ACC/B through the same mapping.
    always_comb begin
        mul_sum   = {1'b0, part_hi} + (part_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {part_hi, part_lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opnd};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            is_div  <= 1'b0;
            opnd    <= '0;
            part_hi <= '0;
            part_lo <= '0;
            cnt     <= '0;
            last    <= 1'b0;
            acc_q   <= '0;
            b_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div  <= bus.op_div;
                        cnt     <= '0;
                        last    <= 1'b0;
                        part_hi <= '0;
                        if (bus.op_div) begin
                            opnd    <= bus.b_in;
                            part_lo <= bus.acc_in;
                            if (bus.b_in == '0) begin
                                acc_q <= bus.acc_in;
                                b_q   <= '0;
                                ov_q  <= 1'b1;
                            end
                        end else begin
                            opnd    <= bus.acc_in;
                            part_lo <= bus.b_in;
                        end
                    end
                end
                CALC: begin
                    if (last) begin
                        acc_q <= part_lo;
                        b_q   <= part_hi;
                        ov_q  <= !is_div && (part_hi != '0);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_W - 1)) last <= 1'b1;
                        if (is_div) begin
                            // Restoring step: keep the shifted remainder when the trial subtract goes negative.
                            if (!div_diff[DATA_W]) begin
                                part_hi <= div_diff[DATA_W-1:0];
                                part_lo <= {part_lo[DATA_W-2:0], 1'b1};
                            end else begin
                                part_hi <= div_shift[DATA_W-1:0];
                                part_lo <= {part_lo[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            part_hi <= mul_sum[DATA_W:1];
                            part_lo <= {mul_sum[0], part_lo[DATA_W-1:1]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.acc_out = acc_q;
    assign bus.b_out   = b_q;
    assign bus.ov_out  = ov_q;
    assign bus.cy_out  = 1'b0;
endmodule
